// File: rtl/output_layer_mac.sv
// Output-layer classifier: one MAC unit walks the 10x30 weight array to build biased class scores.
// After the last neuron, argmax selects the recognised digit.
module output_layer_mac #(
    parameter int N_IN       = 30,
    parameter int N_OUT      = 10,
    parameter int DATA_W     = 8,
    parameter int ACC_W      = 24,
    parameter int BIAS_SHIFT = 4
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   start,
    input  logic [N_IN-1:0][DATA_W-1:0]            activations,
    input  logic [N_OUT-1:0][N_IN-1:0][DATA_W-1:0] weights_HL,
    input  logic [N_OUT-1:0][DATA_W-1:0]           biases_HL,
    output logic                                   busy,
    output logic                                   done,
    output logic [N_OUT-1:0][ACC_W-1:0]            scores,
    output logic [3:0]                             digit,
    output logic                                   digit_valid
);

    // state | meaning
    // IDLE  | waiting for start; results of the last run are held
    // MAC   | one activation*weight product accumulated per cycle
    // FIN   | store score, update argmax, load next bias
    // DONE  | single-cycle done pulse, then back to IDLE
    typedef enum logic [1:0] {IDLE, MAC, FIN, DONE} state_t;

    localparam int JW = $clog2(N_IN);

    state_t                      state, state_nx;
    logic [N_IN-1:0][DATA_W-1:0] act_q;
    logic [JW-1:0]               j;
    logic [3:0]                  n;
    logic [3:0]                  n_next;
    logic signed [ACC_W-1:0]     acc, best;
    logic signed [DATA_W-1:0]    a_sel, w_sel;
    logic signed [2*DATA_W-1:0]  prod;
    logic signed [ACC_W-1:0]     prod_ext;
    logic                        j_last, n_last;

    function automatic logic signed [ACC_W-1:0] bias_scaled(input logic [DATA_W-1:0] b);
        logic signed [ACC_W-1:0] ext;
        ext = {{(ACC_W-DATA_W){b[DATA_W-1]}}, b};
        return ext <<< BIAS_SHIFT;
    endfunction

    assign a_sel    = act_q[j];
    assign w_sel    = weights_HL[n][j];
    assign prod     = a_sel * w_sel;
    assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    assign n_next   = n + 4'd1;
    assign j_last   = (j == JW'(N_IN-1));
    assign n_last   = (n == 4'(N_OUT-1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: if (start) state_nx = MAC;
            MAC: begin
                busy = 1'b1;
                if (j_last) state_nx = FIN;
            end
            FIN: begin
                busy     = 1'b1;
                state_nx = n_last ? DONE : MAC;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q       <= '0;
            j           <= '0;
            n           <= '0;
            acc         <= '0;
            best        <= '0;
            scores      <= '0;
            digit       <= '0;
            digit_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    act_q       <= activations;
                    j           <= '0;
                    n           <= '0;
                    acc         <= bias_scaled(biases_HL[0]);
                    digit_valid <= 1'b0;
                end
                MAC: begin
                    acc <= acc + prod_ext;
                    if (!j_last) j <= j + 1'b1;
                end
                FIN: begin
                    scores[n] <= acc;
                    // strict compare: ties keep the lower class index
                    if (n == 4'd0 || acc > best) begin
                        best  <= acc;
                        digit <= n;
                    end
                    if (n_last) begin
                        digit_valid <= 1'b1;
                    end else begin
                        n   <= n_next;
                        j   <= '0;
                        acc <= bias_scaled(biases_HL[n_next]);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_output_layer_mac.sv
// Directed and random inference runs against a plain-arithmetic classifier model.
module tb_output_layer_mac;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    start = 1'b0;
    logic [29:0][7:0]        act;
    logic [9:0][29:0][7:0]   w;
    logic [9:0][7:0]         b;
    logic                    busy, done, digit_valid;
    logic [9:0][23:0]        scores;
    logic [3:0]              digit;

    int total = 0;
    int bad   = 0;
    int exp_s [10];
    int exp_d;

    always #5 clk = ~clk;

    output_layer_mac dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .activations(act), .weights_HL(w), .biases_HL(b),
        .busy(busy), .done(done), .scores(scores),
        .digit(digit), .digit_valid(digit_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: score = bias*16 + sum(a*w); argmax with first-maximum wins.
    function automatic void model();
        for (int i = 0; i < 10; i++) begin
            exp_s[i] = int'($signed(b[i])) * 16;
            for (int k = 0; k < 30; k++)
                exp_s[i] += int'($signed(act[k])) * int'($signed(w[i][k]));
        end
        exp_d = 0;
        for (int i = 1; i < 10; i++)
            if (exp_s[i] > exp_s[exp_d]) exp_d = i;
    endfunction

    task automatic clear_inputs();
        act = '0; w = '0; b = '0;
    endtask

    task automatic check_results(input string tag);
        logic [23:0] e;
        for (int i = 0; i < 10; i++) begin
            e = exp_s[i][23:0];
            chk($sformatf("%s_score%0d", tag, i), {8'd0, scores[i]}, {8'd0, e});
        end
        chk({tag, "_digit"}, {28'd0, digit}, exp_d);
        chk({tag, "_valid"}, {31'd0, digit_valid}, 32'd1);
    endtask

    // perturb: re-pulse start and scramble activations at edge 100 of the run
    task automatic do_run(input string tag, input bit perturb);
        int  k;
        bit  busy_ok;
        model();
        @(negedge clk); start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        k = 0; busy_ok = 1'b1;
        while (!done && k < 400) begin
            if (!busy) busy_ok = 1'b0;
            if (perturb && k == 100) begin
                start = 1'b1;
                act   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            end
            if (perturb && k == 101) start = 1'b0;
            @(posedge clk); k++;
            @(negedge clk);
        end
        chk({tag, "_latency"}, k, 32'd310);
        chk({tag, "_busy_span"}, {31'd0, busy_ok}, 32'd1);
        chk({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
        check_results(tag);
        @(posedge clk); @(negedge clk);
        chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        chk({tag, "_valid_hold"}, {31'd0, digit_valid}, 32'd1);
    endtask

    initial begin
        int seen_done;
        clear_inputs();
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_digit", {28'd0, digit}, 32'd0);
        chk("rst_valid", {31'd0, digit_valid}, 32'd0);
        chk("rst_score9", {8'd0, scores[9]}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // bias only
        clear_inputs();
        for (int i = 0; i < 10; i++) b[i] = 8'(i);
        do_run("bias", 1'b0);

        // single hot neuron
        clear_inputs();
        for (int k = 0; k < 30; k++) begin act[k] = 8'd1; w[3][k] = 8'd1; end
        do_run("hot", 1'b0);

        // extremes
        clear_inputs();
        for (int k = 0; k < 30; k++) begin act[k] = 8'h80; w[7][k] = 8'h80; end
        b[7] = 8'd127;
        do_run("extreme", 1'b0);
        chk("extreme_value", {8'd0, scores[7]}, 32'd493552);

        // all zero tie
        clear_inputs();
        do_run("zero", 1'b0);

        // tie between classes 2 and 5, class 8 negative
        clear_inputs();
        act[0] = 8'd1; w[2][0] = 8'd40; w[5][0] = 8'd40; w[8][0] = 8'hF0;
        do_run("tie", 1'b0);

        // random runs, one with start/activation disturbance mid-run
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 10; i++) begin
                b[i] = 8'($urandom);
                for (int k = 0; k < 30; k++) w[i][k] = 8'($urandom);
            end
            for (int k = 0; k < 30; k++) act[k] = 8'($urandom);
            do_run($sformatf("rand%0d", r), r == 1);
        end

        // reset mid-run
        for (int k = 0; k < 30; k++) act[k] = 8'($urandom);
        @(negedge clk); start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        seen_done = 0;
        for (int k = 0; k < 149; k++) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_valid", {31'd0, digit_valid}, 32'd0);
        chk("midrst_digit", {28'd0, digit}, 32'd0);
        for (int i = 0; i < 10; i++)
            chk($sformatf("midrst_score%0d", i), {8'd0, scores[i]}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < 320; k++) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        chk("midrst_no_done", seen_done, 32'd0);
        chk("midrst_idle", {31'd0, busy}, 32'd0);

        // fresh run after reset
        for (int i = 0; i < 10; i++) begin
            b[i] = 8'($urandom);
            for (int k = 0; k < 30; k++) w[i][k] = 8'($urandom);
        end
        do_run("after_rst", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
